decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised RV32I instruction-decode pipeline stage. Sits between the IF/ID buffer and EX.
- Decodes one instruction per cycle with valid/ready handshakes on both sides.
- Forwards operands from EX and MEM, detects load-use hazards and stalls on them.
- Resolves all jumps and branches in ID, then issues a one-cycle redirect to fetch.

Parameters:
XLEN, 32, data/register width
ADDR_W, 32, instruction address width
FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = forwarding off, stall on any RAW against EX or MEM
BR_IN_ID, 1, 1 = branches/JALR resolved in ID; 0 = only JAL redirects, others passed to EX with br_valid=0

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  squash stage contents (from later-stage redirect)
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts in_pc/in_inst this cycle
in_pc  in  ADDR_W  instruction address
in_inst  in  32  instruction word
rs1_addr  out  5  regfile read address 1 (=in_inst[19:15])
rs2_addr  out  5  regfile read address 2 (=in_inst[24:20])
rs1_data  in  XLEN  regfile data 1, same-cycle combinational read
rs2_data  in  XLEN  regfile data 2
ex_wen  in  1  EX instruction writes rd
ex_rd  in  5  EX destination
ex_is_load  in  1  EX instruction is a load
ex_result  in  XLEN  EX result
mem_wen  in  1  MEM instruction writes rd
mem_rd  in  5  MEM destination
mem_result  in  XLEN  MEM result
out_valid  out  1  decoded instruction valid
out_ready  in  1  EX accepts
out_aluop  out  6  operation code (package enum)
out_alusel  out  3  result class (package enum)
out_op1  out  XLEN  forwarded rs1 value
out_op2  out  XLEN  forwarded rs2 value
out_imm  out  XLEN  sign-extended immediate
out_rd  out  5  destination
out_wreg  out  1  write enable
out_pc  out  ADDR_W  instruction pc
out_link  out  ADDR_W  pc+4
out_illegal  out  1  unrecognised opcode/funct
br_valid  out  1  one-cycle redirect pulse
br_target  out  ADDR_W  redirect address

Behaviour:
- Reset: all registered outputs 0, out_valid=0, br_valid=0; out_aluop=NOP, out_alusel=NOP.
- Accept: when in_valid && in_ready.
- in_ready = !rst && !flush && !br_valid && !stall && (!out_valid || out_ready).
- Latency: one cycle from acceptance to out_valid and br_valid.
- Backpressure: while out_valid && !out_ready, all out_* are held stable.
- Dequeue without accept: out_valid clears (bubble).
- Immediates: I/S/B/U/J all sign-extended from inst[31]. This is a required behaviour change from the current decoder, which zero-extends.
- x0 handling: a source of x0 reads as 0 and is never forwarded.
- Forwarding (FWD_EN=1):
  - Source matches ex_rd with ex_wen && !ex_is_load → ex_result.
  - Otherwise, match on mem_rd with mem_wen → mem_result.
  - Otherwise → regfile data.
  - EX has priority over MEM.
- Stall conditions:
  - Load-use: ex_wen && ex_is_load && ex_rd!=0 && ex_rd equals a used source.
  - FWD_EN=0: any used source matching a writing EX or MEM rd.
- Used sources: JALR, LOAD and ALU_IMM use rs1 only. BRANCH, STORE and ALU_REG use rs1 and rs2. LUI, AUIPC and JAL use none.
- Branch/jump resolution (BR_IN_ID=1):
  - JAL → target pc+imm_j.
  - JALR → (op1+imm_i) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU → exact RV32I semantics: signed compares for BLT/BGE, unsigned for BLTU/BGEU, >= for BGE/BGEU; taken target is pc+imm_b.
  - Resolution uses forwarded operands.
- br_valid: asserted for exactly one cycle after acceptance of a taken transfer, independent of out_ready.
  - While br_valid=1, in_ready=0; the wrong-path instruction presented that cycle is not accepted.
  - Fetch discards it and refetches from br_target.
- Illegal instruction: out_valid=1, out_illegal=1, out_wreg=0, aluop NOP.
- Flush:
  - Next cycle out_valid=0 and br_valid=0; no accept in the flush cycle.
  - flush overrides both stall and accept.
  - Flush concurrent with br_valid: br_valid still reads 1 that cycle; the next cycle is 0.
- Reset mid-operation: discards everything next cycle; outputs return to reset values.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode, funct3 and funct7 constants;
  - aluop enum (6b) and alusel enum (3b);
  - NOP encodings and the x0 constant.
- Sub-module rv_imm_gen: combinational immediate generator, inst → {imm_i, imm_s, imm_b, imm_u, imm_j}.
- Forwarding muxes, hazard logic, branch comparator and output register stay in decode_stage.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093) accepted, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFB, out_rd=1, out_wreg=1, br_valid=0.
- BGE with rs1=5, rs2=5, pc=0x100, imm_b=+16 → br_valid pulse 1 cycle, br_target=0x110. Repeat with rs1=4 → br_valid=0.
- LW x3 in EX (ex_is_load=1, ex_rd=3) while ADD x4,x3,x2 presented → in_ready=0. Next cycle, with ex_is_load=0 and ex_result=0x55, the ADD is accepted and out_op1=0x55.
- ex_rd=mem_rd=7, both writing, ex_result=0xA, mem_result=0xB, instruction reads x7 → out_op1=0xA. Same test with source x0 → out_op1=0.
- out_ready=0 for 3 cycles with out_valid=1 → out_* stable and in_ready=0. When out_ready rises, the next instruction is captured.
- flush asserted the cycle JAL (pc=0x200, imm=+8) is accepted → br_valid=0 and out_valid=0 next cycle. rst mid-stall → all outputs return to reset values.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, ALU operation
// and result-class enums, NOP encodings and the x0 register index.
// Ports: none (package).
package rv_decode_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // ALU funct3
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  // funct7
  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [4:0]  RegX0   = 5'd0;
  localparam logic [31:0] InstNop = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [5:0] {
    AluNop   = 6'd0,
    AluAdd   = 6'd1,
    AluSub   = 6'd2,
    AluSll   = 6'd3,
    AluSlt   = 6'd4,
    AluSltu  = 6'd5,
    AluXor   = 6'd6,
    AluSrl   = 6'd7,
    AluSra   = 6'd8,
    AluOr    = 6'd9,
    AluAnd   = 6'd10,
    AluLui   = 6'd11,
    AluAuipc = 6'd12,
    AluJal   = 6'd13,
    AluJalr  = 6'd14,
    AluBeq   = 6'd15,
    AluBne   = 6'd16,
    AluBlt   = 6'd17,
    AluBge   = 6'd18,
    AluBltu  = 6'd19,
    AluBgeu  = 6'd20,
    AluLb    = 6'd21,
    AluLh    = 6'd22,
    AluLw    = 6'd23,
    AluLbu   = 6'd24,
    AluLhu   = 6'd25,
    AluSb    = 6'd26,
    AluSh    = 6'd27,
    AluSw    = 6'd28
  } aluop_e;

  typedef enum logic [2:0] {
    SelNop    = 3'd0,
    SelArith  = 3'd1,
    SelLogic  = 3'd2,
    SelShift  = 3'd3,
    SelJump   = 3'd4,
    SelBranch = 3'd5,
    SelLoad   = 3'd6,
    SelStore  = 3'd7
  } alusel_e;

  // Result class of an operation; LUI/AUIPC count as arithmetic.
  function automatic alusel_e alu_class(aluop_e op);
    case (op)
      AluAdd, AluSub, AluSlt, AluSltu, AluLui, AluAuipc: alu_class = SelArith;
      AluXor, AluOr, AluAnd:                             alu_class = SelLogic;
      AluSll, AluSrl, AluSra:                            alu_class = SelShift;
      AluJal, AluJalr:                                   alu_class = SelJump;
      AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu:  alu_class = SelBranch;
      AluLb, AluLh, AluLw, AluLbu, AluLhu:               alu_class = SelLoad;
      AluSb, AluSh, AluSw:                               alu_class = SelStore;
      default:                                           alu_class = SelNop;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rv_imm_gen: combinational RV32I immediate generator.
// All immediate formats are sign-extended from inst[31] to XLEN.
// Ports:
//   i_inst   instruction bits [31:7] (opcode field not needed)
//   o_imm_i/s/b/u/j  sign-extended immediates for each format
module rv_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     i_inst,
  output logic [XLEN-1:0] o_imm_i,
  output logic [XLEN-1:0] o_imm_s,
  output logic [XLEN-1:0] o_imm_b,
  output logic [XLEN-1:0] o_imm_u,
  output logic [XLEN-1:0] o_imm_j
);

  logic [31:0] w_i, w_s, w_b, w_u, w_j;

  assign w_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_u = {i_inst[31:12], 12'b0};
  assign w_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  assign o_imm_i = XLEN'($signed(w_i));
  assign o_imm_s = XLEN'($signed(w_s));
  assign o_imm_b = XLEN'($signed(w_b));
  assign o_imm_u = XLEN'($signed(w_u));
  assign o_imm_j = XLEN'($signed(w_j));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction-decode pipeline stage.
// Decodes one instruction per cycle, forwards operands from EX/MEM, stalls on
// load-use (or any RAW when forwarding is off), resolves jumps/branches and
// emits a one-cycle redirect pulse to fetch.
// Ports:
//   clk, rst (sync, active-high), flush (squash stage contents)
//   in_valid/in_ready/in_pc/in_inst     : IF/ID handshake
//   rs1_addr/rs2_addr, rs1_data/rs2_data: regfile read (combinational)
//   ex_*, mem_*                         : forwarding / hazard sources
//   out_valid/out_ready/out_*           : ID/EX handshake and decoded fields
//   br_valid/br_target                  : redirect to fetch
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned BR_IN_ID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_inst,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              ex_wen,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_wen,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_aluop,
  output logic [2:0]        out_alusel,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rd,
  output logic              out_wreg,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_link,
  output logic              out_illegal,
  output logic              br_valid,
  output logic [ADDR_W-1:0] br_target
);

  // Instruction fields
  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1, w_rs2;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];
  assign w_rs1    = in_inst[19:15];
  assign w_rs2    = in_inst[24:20];
  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  rv_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_inst  (in_inst[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  aluop_e          w_aluop;
  logic [XLEN-1:0] w_imm;
  logic            w_writes, w_use1, w_use2;
  logic            w_is_jal, w_is_jalr, w_is_br, w_illegal;

  always_comb begin
    w_aluop   = AluNop;
    w_imm     = '0;
    w_writes  = 1'b0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_is_jal  = 1'b0;
    w_is_jalr = 1'b0;
    w_is_br   = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OpcLui: begin
        w_aluop  = AluLui;
        w_imm    = w_imm_u;
        w_writes = 1'b1;
      end
      OpcAuipc: begin
        w_aluop  = AluAuipc;
        w_imm    = w_imm_u;
        w_writes = 1'b1;
      end
      OpcJal: begin
        w_aluop  = AluJal;
        w_imm    = w_imm_j;
        w_writes = 1'b1;
        w_is_jal = 1'b1;
      end
      OpcJalr: begin
        w_aluop   = AluJalr;
        w_imm     = w_imm_i;
        w_writes  = 1'b1;
        w_use1    = 1'b1;
        w_is_jalr = 1'b1;
        w_illegal = (w_funct3 != 3'b000);
      end
      OpcBranch: begin
        w_imm   = w_imm_b;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_is_br = 1'b1;
        case (w_funct3)
          F3Beq:   w_aluop = AluBeq;
          F3Bne:   w_aluop = AluBne;
          F3Blt:   w_aluop = AluBlt;
          F3Bge:   w_aluop = AluBge;
          F3Bltu:  w_aluop = AluBltu;
          F3Bgeu:  w_aluop = AluBgeu;
          default: w_illegal = 1'b1;
        endcase
      end
      OpcLoad: begin
        w_imm    = w_imm_i;
        w_writes = 1'b1;
        w_use1   = 1'b1;
        case (w_funct3)
          F3Lb:    w_aluop = AluLb;
          F3Lh:    w_aluop = AluLh;
          F3Lw:    w_aluop = AluLw;
          F3Lbu:   w_aluop = AluLbu;
          F3Lhu:   w_aluop = AluLhu;
          default: w_illegal = 1'b1;
        endcase
      end
      OpcStore: begin
        w_imm  = w_imm_s;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        case (w_funct3)
          F3Sb:    w_aluop = AluSb;
          F3Sh:    w_aluop = AluSh;
          F3Sw:    w_aluop = AluSw;
          default: w_illegal = 1'b1;
        endcase
      end
      OpcOpImm: begin
        w_imm    = w_imm_i;
        w_writes = 1'b1;
        w_use1   = 1'b1;
        case (w_funct3)
          F3AddSub: w_aluop = AluAdd;
          F3Slt:    w_aluop = AluSlt;
          F3Sltu:   w_aluop = AluSltu;
          F3Xor:    w_aluop = AluXor;
          F3Or:     w_aluop = AluOr;
          F3And:    w_aluop = AluAnd;
          F3Sll: begin
            if (w_funct7 == F7Base) w_aluop = AluSll;
            else                    w_illegal = 1'b1;
          end
          default: begin  // F3SrlSra
            if (w_funct7 == F7Base)     w_aluop = AluSrl;
            else if (w_funct7 == F7Alt) w_aluop = AluSra;
            else                        w_illegal = 1'b1;
          end
        endcase
      end
      OpcOp: begin
        w_writes = 1'b1;
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        if (w_funct7 == F7Base) begin
          case (w_funct3)
            F3AddSub: w_aluop = AluAdd;
            F3Sll:    w_aluop = AluSll;
            F3Slt:    w_aluop = AluSlt;
            F3Sltu:   w_aluop = AluSltu;
            F3Xor:    w_aluop = AluXor;
            F3SrlSra: w_aluop = AluSrl;
            F3Or:     w_aluop = AluOr;
            default:  w_aluop = AluAnd;
          endcase
        end else if (w_funct7 == F7Alt && w_funct3 == F3AddSub) begin
          w_aluop = AluSub;
        end else if (w_funct7 == F7Alt && w_funct3 == F3SrlSra) begin
          w_aluop = AluSra;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase

    // Illegal encodings become a NOP that only carries the illegal flag.
    if (w_illegal) begin
      w_aluop   = AluNop;
      w_imm     = '0;
      w_writes  = 1'b0;
      w_use1    = 1'b0;
      w_use2    = 1'b0;
      w_is_jal  = 1'b0;
      w_is_jalr = 1'b0;
      w_is_br   = 1'b0;
    end
  end

  logic [4:0] w_rd;
  logic       w_wreg;

  // Writes to x0 are dropped here so later stages never see a live x0 write.
  assign w_rd   = w_writes ? in_inst[11:7] : RegX0;
  assign w_wreg = w_writes && (w_rd != RegX0);

  // ---------------------------------------------------------------------------
  // Operand forwarding (EX over MEM over regfile; x0 always zero)
  // ---------------------------------------------------------------------------
  logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;

  assign w_ex_hit1  = ex_wen  && (w_rs1 != RegX0) && (ex_rd  == w_rs1);
  assign w_ex_hit2  = ex_wen  && (w_rs2 != RegX0) && (ex_rd  == w_rs2);
  assign w_mem_hit1 = mem_wen && (w_rs1 != RegX0) && (mem_rd == w_rs1);
  assign w_mem_hit2 = mem_wen && (w_rs2 != RegX0) && (mem_rd == w_rs2);

  logic [XLEN-1:0] w_op1, w_op2;

  always_comb begin
    w_op1 = rs1_data;
    if (w_rs1 == RegX0)                                  w_op1 = '0;
    else if ((FWD_EN != 0) && w_ex_hit1 && !ex_is_load)  w_op1 = ex_result;
    else if ((FWD_EN != 0) && w_mem_hit1)                w_op1 = mem_result;

    w_op2 = rs2_data;
    if (w_rs2 == RegX0)                                  w_op2 = '0;
    else if ((FWD_EN != 0) && w_ex_hit2 && !ex_is_load)  w_op2 = ex_result;
    else if ((FWD_EN != 0) && w_mem_hit2)                w_op2 = mem_result;
  end

  // ---------------------------------------------------------------------------
  // Hazards
  // ---------------------------------------------------------------------------
  logic w_load_use, w_raw_nofwd, w_stall;

  assign w_load_use  = ex_is_load && ((w_use1 && w_ex_hit1) || (w_use2 && w_ex_hit2));
  assign w_raw_nofwd = (FWD_EN == 0) &&
                       ((w_use1 && (w_ex_hit1 || w_mem_hit1)) ||
                        (w_use2 && (w_ex_hit2 || w_mem_hit2)));
  assign w_stall     = w_load_use || w_raw_nofwd;

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  logic              w_cond, w_taken;
  logic [XLEN-1:0]   w_jalr_sum;
  logic [ADDR_W-1:0] w_target;

  always_comb begin
    case (w_funct3)
      F3Beq:   w_cond = (w_op1 == w_op2);
      F3Bne:   w_cond = (w_op1 != w_op2);
      F3Blt:   w_cond = ($signed(w_op1) <  $signed(w_op2));
      F3Bge:   w_cond = ($signed(w_op1) >= $signed(w_op2));
      F3Bltu:  w_cond = (w_op1 <  w_op2);
      F3Bgeu:  w_cond = (w_op1 >= w_op2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = (BR_IN_ID != 0) ? (w_is_jal || w_is_jalr || (w_is_br && w_cond))
                                   : w_is_jal;

  assign w_jalr_sum = w_op1 + w_imm_i;

  always_comb begin
    if (w_is_jal)       w_target = in_pc + w_imm_j[ADDR_W-1:0];
    else if (w_is_jalr) w_target = {w_jalr_sum[ADDR_W-1:1], 1'b0};
    else                w_target = in_pc + w_imm_b[ADDR_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic w_in_ready, w_accept;

  logic              r_out_valid, r_wreg, r_illegal, r_br_valid;
  aluop_e            r_aluop;
  alusel_e           r_alusel;
  logic [XLEN-1:0]   r_op1, r_op2, r_imm;
  logic [4:0]        r_rd;
  logic [ADDR_W-1:0] r_pc, r_link, r_br_target;

  // flush and an outstanding redirect both block acceptance, so they also
  // override any stall without further qualification.
  assign w_in_ready = !rst && !flush && !r_br_valid && !w_stall && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_aluop     <= AluNop;
      r_alusel    <= SelNop;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_wreg      <= 1'b0;
      r_pc        <= '0;
      r_link      <= '0;
      r_illegal   <= 1'b0;
      r_br_valid  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_br_valid <= w_accept && w_taken;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_aluop     <= w_aluop;
        r_alusel    <= alu_class(w_aluop);
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_imm       <= w_imm;
        r_rd        <= w_rd;
        r_wreg      <= w_wreg;
        r_pc        <= in_pc;
        r_link      <= in_pc + ADDR_W'(4);
        r_illegal   <= w_illegal;
        if (w_taken) r_br_target <= w_target;
      end else if (flush || out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_aluop   = r_aluop;
  assign out_alusel  = r_alusel;
  assign out_op1     = r_op1;
  assign out_op2     = r_op2;
  assign out_imm     = r_imm;
  assign out_rd      = r_rd;
  assign out_wreg    = r_wreg;
  assign out_pc      = r_pc;
  assign out_link    = r_link;
  assign out_illegal = r_illegal;
  assign br_valid    = r_br_valid;
  assign br_target   = r_br_target;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import rv_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_wen, ex_is_load, mem_wen;
  logic [4:0]  ex_rd, mem_rd;
  logic [31:0] ex_result, mem_result;
  logic        out_valid, out_ready, out_wreg, out_illegal, br_valid;
  logic [5:0]  out_aluop;
  logic [2:0]  out_alusel;
  logic [31:0] out_op1, out_op2, out_imm, out_pc, out_link, br_target;
  logic [4:0]  out_rd;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN     (32),
    .ADDR_W   (32),
    .FWD_EN   (1),
    .BR_IN_ID (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .ex_wen      (ex_wen),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_result   (ex_result),
    .mem_wen     (mem_wen),
    .mem_rd      (mem_rd),
    .mem_result  (mem_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluop   (out_aluop),
    .out_alusel  (out_alusel),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_imm     (out_imm),
    .out_rd      (out_rd),
    .out_wreg    (out_wreg),
    .out_pc      (out_pc),
    .out_link    (out_link),
    .out_illegal (out_illegal),
    .br_valid    (br_valid),
    .br_target   (br_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction encodings (hand-assembled)
  localparam logic [31:0] IAddiNeg5 = 32'hFFB0_0093;  // addi x1,x0,-5
  localparam logic [31:0] IAdd432   = 32'h0021_8233;  // add  x4,x3,x2
  localparam logic [31:0] IBge      = 32'h0020_D863;  // bge  x1,x2,+16
  localparam logic [31:0] IBlt      = 32'h0020_C863;  // blt  x1,x2,+16
  localparam logic [31:0] IBltu     = 32'h0020_E863;  // bltu x1,x2,+16
  localparam logic [31:0] IAddiX7   = 32'h0003_8293;  // addi x5,x7,0
  localparam logic [31:0] IAddiX0   = 32'h0000_0293;  // addi x5,x0,0
  localparam logic [31:0] IJal8     = 32'h0080_00EF;  // jal  x1,+8
  localparam logic [31:0] IBad      = 32'hFFFF_FFFF;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    rs1_data = '0; rs2_data = '0; ex_wen = 1'b0; ex_rd = '0; ex_is_load = 1'b0;
    ex_result = '0; mem_wen = 1'b0; mem_rd = '0; mem_result = '0; out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_br_valid", {31'b0, br_valid}, 32'd0);
    check("rst_aluop", {26'b0, out_aluop}, 32'd0);
    check("rst_alusel", {29'b0, out_alusel}, 32'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,-5
    in_valid = 1'b1; in_pc = 32'h0; in_inst = IAddiNeg5; rs1_data = 32'h1234;
    #1 check("addi_in_ready", {31'b0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    check("addi_valid", {31'b0, out_valid}, 32'd1);
    check("addi_imm", out_imm, 32'hFFFF_FFFB);
    check("addi_rd", {27'b0, out_rd}, 32'd1);
    check("addi_wreg", {31'b0, out_wreg}, 32'd1);
    check("addi_br", {31'b0, br_valid}, 32'd0);
    check("addi_op1_x0", out_op1, 32'd0);
    check("addi_aluop", {26'b0, out_aluop}, 32'(AluAdd));
    check("addi_link", out_link, 32'h4);
    tick();
    check("bubble_valid", {31'b0, out_valid}, 32'd0);

    // BGE taken (5 >= 5); wrong-path instruction must not be accepted
    in_valid = 1'b1; in_pc = 32'h100; in_inst = IBge; rs1_data = 32'd5; rs2_data = 32'd5;
    tick();
    in_pc = 32'h104; in_inst = IAddiNeg5;
    #1;
    check("bge_br_valid", {31'b0, br_valid}, 32'd1);
    check("bge_target", br_target, 32'h110);
    check("bge_wreg", {31'b0, out_wreg}, 32'd0);
    check("bge_in_ready_blk", {31'b0, in_ready}, 32'd0);
    tick(); in_valid = 1'b0;
    check("bge_pulse_end", {31'b0, br_valid}, 32'd0);
    check("bge_wrongpath", {31'b0, out_valid}, 32'd0);

    // BGE not taken (4 >= 5 false)
    in_valid = 1'b1; in_pc = 32'h100; in_inst = IBge; rs1_data = 32'd4;
    tick(); in_valid = 1'b0;
    check("bge_nt_br", {31'b0, br_valid}, 32'd0);
    check("bge_nt_valid", {31'b0, out_valid}, 32'd1);

    // BLT signed: -1 < 1 taken
    in_valid = 1'b1; in_inst = IBlt; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
    tick(); in_valid = 1'b0;
    check("blt_br", {31'b0, br_valid}, 32'd1);
    check("blt_target", br_target, 32'h110);
    tick();

    // BLTU: 0xFFFFFFFF < 1 unsigned is false
    in_valid = 1'b1; in_inst = IBltu;
    tick(); in_valid = 1'b0;
    check("bltu_br", {31'b0, br_valid}, 32'd0);

    // Load-use stall, then forward once the load result is in EX
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    in_valid = 1'b1; in_pc = 32'h140; in_inst = IAdd432; rs1_data = 32'h11; rs2_data = 32'h22;
    #1 check("lu_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("lu_no_accept", {31'b0, out_valid}, 32'd0);
    ex_is_load = 1'b0; ex_result = 32'h55;
    #1 check("lu_release", {31'b0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0; ex_wen = 1'b0;
    check("lu_op1", out_op1, 32'h55);
    check("lu_op2", out_op2, 32'h22);
    check("lu_rd", {27'b0, out_rd}, 32'd4);

    // Forward priority: EX over MEM, then MEM, then x0
    ex_wen = 1'b1; ex_rd = 5'd7; ex_result = 32'hA;
    mem_wen = 1'b1; mem_rd = 5'd7; mem_result = 32'hB;
    in_valid = 1'b1; in_inst = IAddiX7; rs1_data = 32'h99;
    tick();
    check("fwd_ex_prio", out_op1, 32'hA);
    ex_wen = 1'b0;
    tick();
    check("fwd_mem", out_op1, 32'hB);
    ex_wen = 1'b1; ex_rd = 5'd0; mem_rd = 5'd0; in_inst = IAddiX0;
    tick(); in_valid = 1'b0; ex_wen = 1'b0; mem_wen = 1'b0;
    check("fwd_x0", out_op1, 32'd0);

    // Backpressure: hold outputs for 3 cycles
    in_valid = 1'b1; in_pc = 32'h300; in_inst = IAddiNeg5;
    tick();
    out_ready = 1'b0; in_pc = 32'h304; in_inst = IAddiX7; rs1_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'h300);
      check("bp_imm", out_imm, 32'hFFFF_FFFB);
    end
    out_ready = 1'b1;
    #1 check("bp_release", {31'b0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    check("bp_next_pc", out_pc, 32'h304);
    check("bp_next_op1", out_op1, 32'h77);

    // JAL redirect, then flush concurrent with br_valid
    in_valid = 1'b1; in_pc = 32'h200; in_inst = IJal8;
    tick(); in_valid = 1'b0; flush = 1'b1;
    #1;
    check("jal_br", {31'b0, br_valid}, 32'd1);
    check("jal_target", br_target, 32'h208);
    check("jal_link", out_link, 32'h204);
    tick(); flush = 1'b0;
    check("jal_flush_br", {31'b0, br_valid}, 32'd0);
    check("jal_flush_valid", {31'b0, out_valid}, 32'd0);

    // Flush in the cycle a JAL is presented: not accepted
    in_valid = 1'b1; in_pc = 32'h1F0; in_inst = IAddiNeg5;
    tick();
    in_pc = 32'h200; in_inst = IJal8; flush = 1'b1;
    #1 check("fl_in_ready", {31'b0, in_ready}, 32'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    check("fl_br", {31'b0, br_valid}, 32'd0);
    check("fl_valid", {31'b0, out_valid}, 32'd0);

    // Illegal instruction
    in_valid = 1'b1; in_inst = IBad;
    tick(); in_valid = 1'b0;
    check("ill_valid", {31'b0, out_valid}, 32'd1);
    check("ill_flag", {31'b0, out_illegal}, 32'd1);
    check("ill_wreg", {31'b0, out_wreg}, 32'd0);
    check("ill_aluop", {26'b0, out_aluop}, 32'(AluNop));

    // Reset in the middle of a stall
    in_valid = 1'b1; in_pc = 32'h400; in_inst = IAddiNeg5;
    tick();
    out_ready = 1'b0; in_inst = IAdd432; ex_wen = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    tick();
    rst = 1'b1;
    tick();
    check("rst2_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_imm", out_imm, 32'd0);
    check("rst2_pc", out_pc, 32'd0);
    check("rst2_rd", {27'b0, out_rd}, 32'd0);
    check("rst2_aluop", {26'b0, out_aluop}, 32'(AluNop));
    check("rst2_br", {31'b0, br_valid}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; out_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
